ble_cmd_parser: RTL

Sits between the BLE UART receiver and the gameplay module. Consumes the receiver's byte stream (byte plus one-cycle strobe), frames fixed 5-byte command packets, and verifies an XOR checksum. Decoded commands drive gameplay as held control levels: hit charge and camera pan. Raw packet fields and an error count are exported for the seven-segment debug display. Runs in the pixel clock domain.

---
 rtl/ble_cmd_parser.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ble_cmd_parser.sv
// BLE command parser: frames 5-byte packets (SYNC CMD HI LO CHK) from the UART
// byte stream, checks the XOR checksum and drives held gameplay control levels.
module ble_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 32768,
    parameter logic [7:0] CMD_HIT        = 8'h01,
    parameter logic [7:0] CMD_PAN        = 8'h02
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        pkt_valid_out,
    output logic [7:0]  pkt_cmd_out,
    output logic [15:0] pkt_data_out,
    output logic        hit_out,
    output logic        pan_left_out,
    output logic        pan_right_out,
    output logic [7:0]  err_count_out
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_SYNC,
        S_GOT_CMD,
        S_GOT_HI,
        S_GOT_LO
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timeout;

    logic [7:0] cmd_q, cmd_d, hi_q, hi_d, lo_q, lo_d;
    logic valid_q, valid_d;
    logic [7:0] pcmd_q, pcmd_d;
    logic [15:0] pdata_q, pdata_d;
    logic hit_q, hit_d, left_q, left_d, right_q, right_d;
    logic [7:0] err_q, err_d;

    logic chk_seen, chk_ok;
    logic [15:0] payload;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // An accepted byte always beats the timeout, even on the last allowed cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (byte_valid_in) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE:     if (byte_in == SYNC_BYTE) state_d = S_GOT_SYNC;
                S_GOT_SYNC: state_d = S_GOT_CMD;
                S_GOT_CMD:  state_d = S_GOT_HI;
                S_GOT_HI:   state_d = S_GOT_LO;
                S_GOT_LO:   state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            timeout = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign payload  = {hi_q, lo_q};
    assign chk_seen = byte_valid_in && (state_q == S_GOT_LO);
    assign chk_ok   = (byte_in == (cmd_q ^ hi_q ^ lo_q));

    always_comb begin
        cmd_d   = cmd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = 1'b0;
        pcmd_d  = pcmd_q;
        pdata_d = pdata_q;
        hit_d   = hit_q;
        left_d  = left_q;
        right_d = right_q;
        err_d   = err_q;
        if (byte_valid_in && state_q == S_GOT_SYNC) cmd_d = byte_in;
        if (byte_valid_in && state_q == S_GOT_CMD)  hi_d  = byte_in;
        if (byte_valid_in && state_q == S_GOT_HI)   lo_d  = byte_in;
        if (chk_seen && chk_ok) begin
            valid_d = 1'b1;
            pcmd_d  = cmd_q;
            pdata_d = payload;
            if (cmd_q == CMD_HIT) begin
                hit_d = |payload;
            end else if (cmd_q == CMD_PAN) begin
                left_d  = payload[15];
                right_d = !payload[15] && (|payload);
            end
        end
        if (((chk_seen && !chk_ok) || timeout) && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cmd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            pcmd_q  <= '0;
            pdata_q <= '0;
            hit_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            err_q   <= '0;
        end else begin
            cmd_q   <= cmd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            pcmd_q  <= pcmd_d;
            pdata_q <= pdata_d;
            hit_q   <= hit_d;
            left_q  <= left_d;
            right_q <= right_d;
            err_q   <= err_d;
        end
    end

    assign pkt_valid_out = valid_q;
    assign pkt_cmd_out   = pcmd_q;
    assign pkt_data_out  = pdata_q;
    assign hit_out       = hit_q;
    assign pan_left_out  = left_q;
    assign pan_right_out = right_q;
    assign err_count_out = err_q;

endmodule
